// File: rtl/march_sequencer.sv
// march_sequencer: sequences March memory-test elements onto the address counter and memory datapath
// Ports:
//   clk, rst (async active-low)          clock and reset
//   start, abort                         run control (start sampled in IDLE; abort returns to IDLE)
//   elem_valid/elem_ready + elem_*       element descriptor handshake from the decoder
//   admd_out, updwn_out, hold_out,
//   s_out, r_out                         address counter control
//   mem_en, mem_we, mem_dpol             per-cycle memory operation
//   busy, done                           run status; done pulses once on normal completion
module march_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int ADMW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  elem_valid,
    output logic                  elem_ready,
    input  logic                  elem_dir,
    input  logic [ADMW-1:0]       elem_admd,
    input  logic [ADDR_WIDTH-1:0] elem_len,
    input  logic [1:0]            elem_nops,
    input  logic [7:0]            elem_ops,
    input  logic                  elem_last,
    output logic [ADMW-1:0]       admd_out,
    output logic                  updwn_out,
    output logic                  hold_out,
    output logic                  s_out,
    output logic                  r_out,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_dpol,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, OP, DONE} state_t;
    state_t                state, nxt;
    logic                  dir_r, last_r;
    logic [ADMW-1:0]       admd_r;
    logic [ADDR_WIDTH-1:0] len_r;
    logic [1:0]            nops_r, op_idx;
    logic [7:0]            ops_r;
    // one extra bit so a full-range element (len = all ones) ends without wrapping
    logic [ADDR_WIDTH:0]   addr_cnt;
    logic                  last_op, elem_end;
    logic [1:0]            op_cur;
    // element end is judged on our own address count, never on the counter's output,
    // so non-linear address modes terminate after exactly len+1 addresses
    always_comb begin
        last_op  = op_idx == nops_r;
        elem_end = last_op && addr_cnt == {1'b0, len_r};
        nxt      = state;
        case (state)
            IDLE:    nxt = start ? FETCH : IDLE;
            FETCH:   nxt = elem_valid ? LOAD : FETCH;
            LOAD:    nxt = OP;
            OP:      nxt = elem_end ? (last_r ? DONE : FETCH) : OP;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            dir_r    <= 1'b0;
            last_r   <= 1'b0;
            admd_r   <= '0;
            len_r    <= '0;
            nops_r   <= '0;
            ops_r    <= '0;
            op_idx   <= '0;
            addr_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == FETCH && elem_valid && !abort) begin
                dir_r  <= elem_dir;
                last_r <= elem_last;
                admd_r <= elem_admd;
                len_r  <= elem_len;
                nops_r <= elem_nops;
                ops_r  <= elem_ops;
            end
            if (state == LOAD) begin
                op_idx   <= '0;
                addr_cnt <= '0;
            end else if (state == OP) begin
                op_idx <= last_op ? 2'd0 : op_idx + 2'd1;
                if (last_op) addr_cnt <= addr_cnt + (ADDR_WIDTH+1)'(1);
            end
        end
    end
    assign op_cur     = ops_r[{op_idx, 1'b0} +: 2];
    assign elem_ready = state == FETCH;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign s_out      = state == LOAD && !dir_r;
    assign r_out      = state == LOAD && dir_r;
    assign admd_out   = admd_r;
    assign updwn_out  = dir_r;
    assign mem_en     = state == OP;
    assign mem_we     = mem_en && op_cur[1];
    assign mem_dpol   = mem_en && op_cur[0];
    // the counter steps only on the edge that ends an address's last operation
    assign hold_out   = !(mem_en && last_op);
endmodule

// File: tb/tb_march_sequencer.sv
// tb_march_sequencer: scoreboard bench for march_sequencer
module tb_march_sequencer;
    logic       clk = 0, rst = 0, start = 0, abort = 0;
    logic       elem_valid = 0, elem_dir = 0, elem_last = 0;
    logic [3:0] elem_admd = 0;
    logic [7:0] elem_len = 0, elem_ops = 0;
    logic [1:0] elem_nops = 0;
    logic       elem_ready, updwn_out, hold_out, s_out, r_out;
    logic       mem_en, mem_we, mem_dpol, busy, done;
    logic [3:0] admd_out;

    march_sequencer #(.ADDR_WIDTH(8), .ADMW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_dir(elem_dir),
        .elem_admd(elem_admd), .elem_len(elem_len), .elem_nops(elem_nops),
        .elem_ops(elem_ops), .elem_last(elem_last), .admd_out(admd_out),
        .updwn_out(updwn_out), .hold_out(hold_out), .s_out(s_out), .r_out(r_out),
        .mem_en(mem_en), .mem_we(mem_we), .mem_dpol(mem_dpol), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // scoreboard entry: {admd, updwn, we, dpol, hold}
    logic [7:0] sb[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_s = 0, n_r = 0, n_mem = 0, n_h0 = 0, n_done = 0;
    int last_mem_cyc = 0, done_cyc = 0;
    int s0, r0, m0, h0, d0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to the next falling edge and observe the DUT there
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mem_en) begin
            if (sb.size() > 0) check("op", {admd_out, updwn_out, mem_we, mem_dpol, hold_out}, {24'd0, sb.pop_front()});
            else check("unexpected_op", mem_en, 1'b0);
            n_mem++;
            last_mem_cyc = cyc;
        end
        n_s += int'(s_out);
        n_r += int'(r_out);
        if (rst && !hold_out) n_h0++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic snap();
        s0 = n_s; r0 = n_r; m0 = n_mem; h0 = n_h0; d0 = n_done;
    endtask

    task automatic expect_elem(input logic dir, input logic [3:0] admd, input int len, input int nops, input logic [7:0] ops);
        for (int a = 0; a <= len; a++)
            for (int k = 0; k <= nops; k++)
                sb.push_back({admd, dir, ops[2*k+1], ops[2*k], logic'(k != nops)});
    endtask

    task automatic send(input logic dir, input logic [3:0] admd, input logic [7:0] len, input logic [1:0] nops, input logic [7:0] ops, input logic last);
        int n = 0;
        elem_dir = dir; elem_admd = admd; elem_len = len; elem_nops = nops; elem_ops = ops; elem_last = last;
        elem_valid = 1;
        while (!elem_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept", elem_ready, 1'b1);
        tick();
        elem_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        int d = n_done;
        while (n_done == d && n < limit) begin
            tick();
            n++;
        end
        check("done_seen", n_done - d, 1);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        int lat;
        repeat (2) tick();
        check("rst_hold", hold_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_ready", elem_ready, 1'b0);
        check("rst_admd_updwn", {admd_out, updwn_out}, 5'd0);
        check("rst_sr_done", {s_out, r_out, done}, 3'd0);
        rst = 1;
        tick();
        check("idle_busy", busy, 1'b0);

        // up element, w0 at 4 addresses, descriptor already valid at start
        snap();
        expect_elem(0, 4'h5, 3, 0, 8'b10);
        elem_dir = 0; elem_admd = 4'h5; elem_len = 3; elem_nops = 0; elem_ops = 8'b10; elem_last = 1;
        elem_valid = 1;
        start = 1;
        tick();
        start = 0;
        lat = 1;
        while (!mem_en && lat < 20) begin
            tick();
            lat++;
        end
        check("start_latency", lat, 3);
        elem_valid = 0;
        wait_done(50);
        check("t1_s", n_s - s0, 1);
        check("t1_r", n_r - r0, 0);
        check("t1_mem", n_mem - m0, 4);
        check("t1_hold0", n_h0 - h0, 4);
        check("t1_done_lat", done_cyc - last_mem_cyc, 1);

        // down element, r0 then w1 at 2 addresses
        snap();
        expect_elem(1, 4'h2, 1, 1, 8'b0000_1100);
        pulse_start();
        send(1, 4'h2, 1, 1, 8'b0000_1100, 1);
        wait_done(50);
        check("t2_r", n_r - r0, 1);
        check("t2_s", n_s - s0, 0);
        check("t2_mem", n_mem - m0, 4);
        check("t2_hold0", n_h0 - h0, 2);

        // two elements with a 3-cycle descriptor gap
        snap();
        expect_elem(0, 4'h1, 2, 0, 8'b11);
        expect_elem(1, 4'h7, 1, 2, 8'b00_10_01);
        pulse_start();
        send(0, 4'h1, 2, 0, 8'b11, 0);
        lat = 0;
        while (!elem_ready && lat < 50) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", elem_ready, 1'b1);
            check("stall_mem_en", mem_en, 1'b0);
            check("stall_hold", hold_out, 1'b1);
            tick();
        end
        send(1, 4'h7, 1, 2, 8'b00_10_01, 1);
        wait_done(50);
        check("t3_mem", n_mem - m0, 9);
        check("t3_loads", {n_s - s0, n_r - r0}, {32'd1, 32'd1});
        check("t3_done", n_done - d0, 1);

        // full-range element, 4 ops per address
        snap();
        expect_elem(0, 4'h3, 255, 3, 8'b1001_1100);
        pulse_start();
        send(0, 4'h3, 255, 3, 8'b1001_1100, 1);
        wait_done(1100);
        check("t4_mem", n_mem - m0, 1024);
        check("t4_hold0", n_h0 - h0, 256);

        // abort on the second OP cycle, then rerun from scratch
        snap();
        expect_elem(0, 4'hA, 1, 0, 8'b10);
        pulse_start();
        send(0, 4'hA, 3, 0, 8'b10, 1);
        tick();
        tick();
        abort = 1;
        tick();
        abort = 0;
        check("abort_busy", busy, 1'b0);
        check("abort_mem_en", mem_en, 1'b0);
        check("abort_ready", elem_ready, 1'b0);
        check("abort_admd_kept", admd_out, 4'hA);
        repeat (3) tick();
        check("abort_no_done", n_done - d0, 0);
        check("abort_mem", n_mem - m0, 2);
        snap();
        expect_elem(0, 4'hA, 3, 0, 8'b10);
        pulse_start();
        send(0, 4'hA, 3, 0, 8'b10, 1);
        wait_done(50);
        check("rerun_s", n_s - s0, 1);
        check("rerun_mem", n_mem - m0, 4);

        // asynchronous reset mid-OP
        snap();
        sb.push_back({4'h6, 1'b0, 1'b1, 1'b0, 1'b1});
        pulse_start();
        send(0, 4'h6, 3, 1, 8'b0000_0110, 1);
        tick();
        #2 rst = 0;
        #1;
        check("arst_hold", hold_out, 1'b1);
        check("arst_mem_en", mem_en, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_admd", admd_out, 4'h0);
        tick();
        rst = 1;
        repeat (3) tick();
        check("arst_no_resume", busy, 1'b0);
        check("arst_mem", n_mem - m0, 1);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/march_sequencer.md
# march_sequencer

Sequences March-style memory tests by driving the address counter's control inputs (`admd`, `hold`, `updwn`, `s`, `r`) and issuing per-address read/write operations to the memory-access datapath. It consumes a stream of March elements from the instruction decoder through a valid/ready handshake. For each element it loads the first or last address, runs 1–4 operations at each address, advances the counter, and moves to the next element. It sits between the instruction register/decoder and `address_counter` inside the PMBIST core.

## Interface
- `ADDR_WIDTH`, default 8: width of the element length field; matches the counter width.
- `ADMW`, default 4: width of the address-mode field; matches the counter's `admd` input.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; starts a test run. Only sampled in IDLE.
- `abort` in 1: synchronous abort; takes effect at the next edge from any state.
- `elem_valid` in 1: an element descriptor is present.
- `elem_ready` out 1: sequencer accepts a descriptor this cycle.
- `elem_dir` in 1: element direction, 0 = up, 1 = down.
- `elem_admd` in ADMW: address mode passed through to the counter.
- `elem_len` in ADDR_WIDTH: number of addresses in the element, minus 1.
- `elem_nops` in 2: number of operations per address, minus 1 (range 1–4 operations).
- `elem_ops` in 8: op k is in bits [2k+1:2k]. Bit 1 = write (1) or read (0); bit 0 = data polarity.
- `elem_last` in 1: this element is the final one of the test.
- `admd_out` out ADMW: to counter `admd_in`.
- `updwn_out` out 1: to counter `updwn_in`; 0 = up, 1 = down.
- `hold_out` out 1: to counter `hold_in`.
- `s_out` out 1: to counter `s_in`.
- `r_out` out 1: to counter `r_in`.
- `mem_en` out 1: a memory operation is valid this cycle.
- `mem_we` out 1: the operation is a write.
- `mem_dpol` out 1: data polarity of the operation.
- `busy` out 1: a test run is in progress.
- `done` out 1: one-cycle pulse when a test completes normally.

## Operation
- States:
  - IDLE: waiting for `start`.
  - FETCH: waiting for an element descriptor.
  - LOAD: loading the first/last address into the counter.
  - OP: issuing operations.
  - DONE: signalling completion.
- IDLE → FETCH on `start`. `busy`=1 in every state except IDLE.
- FETCH:
  - `elem_ready`=1.
  - On `elem_valid`, latch all element fields into registers, then go to LOAD.
  - Otherwise stay in FETCH with `hold_out`=1 and `mem_en`=0.
- LOAD:
  - `s_out`=1 if direction is up; `r_out`=1 if direction is down.
  - `admd_out`/`updwn_out` come from the latched fields.
  - Clear `op_idx` and `addr_cnt` to 0. Go to OP.
- OP, one operation per cycle:
  - `mem_en`=1; `mem_we`/`mem_dpol` = op[`op_idx`].
  - `hold_out`=1 while `op_idx` != nops. On the last op of an address `hold_out`=0, so the counter steps at that edge.
  - On the last op: `op_idx` goes to 0, and `addr_cnt` increments.
  - If `addr_cnt`==len on the last op: go to DONE if `elem_last`, else go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `admd_out`/`updwn_out` hold their latched values until the next element is accepted.
- `abort` overrides everything:
  - Next state is IDLE; `mem_en`=0; `done` is not pulsed.
  - Element registers are retained, but the next run re-fetches.
- `start` outside IDLE is ignored. `elem_valid` outside FETCH is ignored, and the descriptor is not consumed.
- `addr_cnt` is ADDR_WIDTH+1 bits wide, so `elem_len` = 2^ADDR_WIDTH−1 completes without wrap.
- End of an element is decided only by `addr_cnt`, never by the counter's `tas_out`. This makes PRUD/LFSR elements terminate correctly.
- Outputs are a registered state decode; no combinational path from inputs to outputs.
- Exception: `elem_ready` is `(state==FETCH)`.

## Timing
- Reset values:
  - State IDLE.
  - `hold_out`=1.
  - All other outputs 0.
  - `admd_out`=0, `updwn_out`=0.
  - `op_idx`=0, `addr_cnt`=0.
- Latency from `start` to the first `mem_en`: 3 cycles when `elem_valid` is already high (FETCH, LOAD, then OP).
- Cycles per element: 1 FETCH (minimum) + 1 LOAD + (len+1)·(nops+1) OP cycles.
- The address is valid on `tas_out` in every OP cycle. The counter updates at the edge ending LOAD and at the edge ending each address's last op.
- An extra counter step after the final op of an element is harmless; the next LOAD reloads the counter.
- Reset asserted mid-run: outputs go to reset values immediately (asynchronously). A run resumes only after a new `start`.

## Test plan
- Up element, `elem_len`=3, `elem_nops`=0, `elem_ops`=8'b10 (write 0), `elem_last`=1:
  - `s_out` high 1 cycle.
  - `mem_en`=1, `mem_we`=1 for 4 consecutive cycles, with `hold_out`=0 on each.
  - `done` pulses 1 cycle later.
- Down element, `elem_len`=1, `elem_nops`=1, ops = r0 then w1 (8'b0000_1100), last:
  - `r_out` pulses.
  - `mem_en` for 4 cycles with `mem_we` sequence 0,1,0,1 and `hold_out` 1,0,1,0.
  - `updwn_out`=1 throughout.
- Two elements with `elem_valid` low for 3 cycles between them:
  - FETCH stalls 3 cycles with `mem_en`=0 and `hold_out`=1.
  - `elem_ready` is high during the stall.
  - The second element proceeds normally.
- `elem_len`=255, `elem_nops`=3:
  - Exactly 1024 `mem_en` cycles.
  - 256 `hold_out`=0 cycles.
  - No early termination.
- `abort` asserted during the 2nd OP cycle:
  - IDLE next cycle with `busy`=0 and no `done`.
  - A following `start` re-fetches and runs from `s_out`.
- `rst` pulled low mid-OP: `hold_out`=1 and `mem_en`=0 before the next clock edge, with state IDLE.
